// File: rtl/ifetch_unit_pkg.sv
// Shared types and encodings for the instruction fetch unit.
// Provides opcode constants, the operation enum handed to the decoder,
// the fetch FSM state type, default cache/BHT sizes and the B/J immediate
// extraction helpers (the decoder reuses the same immediate rules).
package ifetch_unit_pkg;

  localparam int ICACHE_IDX_W_DEFAULT = 8;
  localparam int BHT_IDX_W_DEFAULT    = 8;

  typedef logic [31:0] inst_t;
  typedef logic [31:0] addr_t;

  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR  = 7'b1100111;
  localparam logic [6:0] OPCODE_BR    = 7'b1100011;
  localparam logic [6:0] OPCODE_LD    = 7'b0000011;
  localparam logic [6:0] OPCODE_ST    = 7'b0100011;
  localparam logic [6:0] OPCODE_ALUI  = 7'b0010011;
  localparam logic [6:0] OPCODE_ALU   = 7'b0110011;

  typedef enum logic [3:0] {
    OPENUM_NOP,
    OPENUM_LUI,
    OPENUM_AUIPC,
    OPENUM_JAL,
    OPENUM_JALR,
    OPENUM_BR,
    OPENUM_LD,
    OPENUM_ST,
    OPENUM_ALUI,
    OPENUM_ALU
  } openum_t;

  typedef enum logic {
    S_IDLE,
    S_MEM_WAIT
  } fetch_state_t;

  function automatic logic signed [31:0] imm_b(input inst_t i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_j(input inst_t i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: memory-controller request/response and the
// instruction stream presented to the decoder.
//   master : fetch unit (drives if_to_mc_*, if_to_dc_*; receives mc_to_if_*)
//   slave  : memory controller / decoder side
interface ifetch_unit_if;
  import ifetch_unit_pkg::*;

  logic    if_to_mc_enable;
  addr_t   if_to_mc_pc;
  logic    mc_to_if_done;
  inst_t   mc_to_if_data;

  logic    if_to_dc_enable;
  inst_t   if_to_dc_inst_val;
  openum_t if_to_dc_openum;
  addr_t   if_to_dc_pc;
  logic    if_to_dc_pred_jump;
  logic    if_to_dc_lsb_enable;
  logic    if_to_dc_rs_enable;

  modport master (
    output if_to_mc_enable, if_to_mc_pc,
    input  mc_to_if_done, mc_to_if_data,
    output if_to_dc_enable, if_to_dc_inst_val, if_to_dc_openum, if_to_dc_pc,
    output if_to_dc_pred_jump, if_to_dc_lsb_enable, if_to_dc_rs_enable
  );

  modport slave (
    input  if_to_mc_enable, if_to_mc_pc,
    output mc_to_if_done, mc_to_if_data,
    input  if_to_dc_enable, if_to_dc_inst_val, if_to_dc_openum, if_to_dc_pc,
    input  if_to_dc_pred_jump, if_to_dc_lsb_enable, if_to_dc_rs_enable
  );

endinterface

// File: rtl/ifetch_unit_openum_decode.sv
// openum_decode: combinational pre-decode of one instruction.
//   inst      in   raw instruction
//   openum    out  operation class
//   lsb_route out  instruction goes to the LSB (loads/stores)
//   rs_route  out  instruction goes to the RS (everything else)
//   imm_b     out  sign-extended branch offset
//   imm_j     out  sign-extended JAL offset
module openum_decode
  import ifetch_unit_pkg::*;
(
  input  inst_t              inst,
  output openum_t            openum,
  output logic               lsb_route,
  output logic               rs_route,
  output logic signed [31:0] imm_b_o,
  output logic signed [31:0] imm_j_o
);

  always_comb begin
    openum = OPENUM_NOP;
    case (inst[6:0])
      OPCODE_LUI:   openum = OPENUM_LUI;
      OPCODE_AUIPC: openum = OPENUM_AUIPC;
      OPCODE_JAL:   openum = OPENUM_JAL;
      OPCODE_JALR:  openum = OPENUM_JALR;
      OPCODE_BR:    openum = OPENUM_BR;
      OPCODE_LD:    openum = OPENUM_LD;
      OPCODE_ST:    openum = OPENUM_ST;
      OPCODE_ALUI:  openum = OPENUM_ALUI;
      OPCODE_ALU:   openum = OPENUM_ALU;
      default:      openum = OPENUM_NOP;
    endcase
  end

  assign lsb_route = (openum == OPENUM_LD) || (openum == OPENUM_ST);
  assign rs_route  = !lsb_route;
  assign imm_b_o   = imm_b(inst);
  assign imm_j_o   = imm_j(inst);

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: front end of the core. Holds the PC and a direct-mapped
// instruction cache (one word per entry), fetches misses through the memory
// controller, predicts branches with a 2-bit BHT and emits at most one
// pre-decoded instruction per cycle to the decoder.
//   clk, rst             clock, synchronous active-high reset
//   rdy                  global enable; low freezes every register
//   clr, rob_to_if_set_pc  mispredict flush and redirect target
//   rob_full/rs_full/lsb_full  downstream back-pressure
//   rob_to_if_br_*       committed conditional branch outcome (BHT training)
//   bus                  memory-controller and decoder interface (master)
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int ICACHE_IDX_W = ICACHE_IDX_W_DEFAULT,
  parameter int BHT_IDX_W    = BHT_IDX_W_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rdy,
  input  logic  clr,
  input  addr_t rob_to_if_set_pc,
  input  logic  rob_full,
  input  logic  rs_full,
  input  logic  lsb_full,
  input  logic  rob_to_if_br_commit,
  input  addr_t rob_to_if_br_pc,
  input  logic  rob_to_if_br_taken,
  ifetch_unit_if.master bus
);

  localparam int IC_N  = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 30 - ICACHE_IDX_W;
  localparam int BHT_N = 1 << BHT_IDX_W;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  addr_t        pc;
  fetch_state_t state;

  logic [IC_N-1:0] ic_valid;
  logic [TAG_W-1:0] ic_tag [IC_N];
  inst_t            ic_data [IC_N];
  logic [1:0]       bht [BHT_N];

  logic                    mc_en_p1;
  addr_t                   mc_pc_p1;
  logic                    dc_vld_p1;
  inst_t                   dc_inst_p1;
  openum_t                 dc_openum_p1;
  addr_t                   dc_pc_p1;
  logic                    dc_pred_p1;
  logic                    dc_lsb_p1;
  logic                    dc_rs_p1;

  logic [ICACHE_IDX_W-1:0] ic_idx;
  logic [TAG_W-1:0]        pc_tag;
  logic                    hit;
  inst_t                   inst_p0;
  openum_t                 openum_p0;
  logic                    lsb_p0;
  logic                    rs_p0;
  logic signed [31:0]      imm_b_p0;
  logic signed [31:0]      imm_j_p0;
  logic [BHT_IDX_W-1:0]    bht_idx;
  logic [BHT_IDX_W-1:0]    commit_idx;
  addr_t                   next_pc;
  logic                    pred_p0;
  logic                    stall;
  logic                    fill;
  logic                    unused_br_pc_bits;

  assign ic_idx     = pc[ICACHE_IDX_W+1:2];
  assign pc_tag     = pc[31:ICACHE_IDX_W+2];
  assign hit        = ic_valid[ic_idx] && (ic_tag[ic_idx] == pc_tag);
  assign inst_p0    = ic_data[ic_idx];
  assign bht_idx    = pc[BHT_IDX_W+1:2];
  assign commit_idx = rob_to_if_br_pc[BHT_IDX_W+1:2];
  assign stall      = rob_full | rs_full | lsb_full;
  // The returned word is correct for its address, so it is kept even when a
  // flush lands on the same edge.
  assign fill       = rdy && (state == S_MEM_WAIT) && bus.mc_to_if_done;

  assign unused_br_pc_bits = ^{rob_to_if_br_pc[31:BHT_IDX_W+2], rob_to_if_br_pc[1:0]};

  openum_decode u_decode (
    .inst      (inst_p0),
    .openum    (openum_p0),
    .lsb_route (lsb_p0),
    .rs_route  (rs_p0),
    .imm_b_o   (imm_b_p0),
    .imm_j_o   (imm_j_p0)
  );

  // JALR and everything else fall through; the ROB fixes JALR via clr.
  always_comb begin
    next_pc = pc + 32'd4;
    pred_p0 = 1'b0;
    if (openum_p0 == OPENUM_JAL) begin
      next_pc = pc + $unsigned(imm_j_p0);
      pred_p0 = 1'b1;
    end else if (openum_p0 == OPENUM_BR && bht[bht_idx][1]) begin
      next_pc = pc + $unsigned(imm_b_p0);
      pred_p0 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      ic_data[ic_idx] <= bus.mc_to_if_data;
      ic_tag[ic_idx]  <= pc_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ic_valid <= '0;
    end else if (fill) begin
      ic_valid[ic_idx] <= 1'b1;
    end
  end

  // Lookup reads the pre-update counter when commit and fetch share an entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (rdy && rob_to_if_br_commit) begin
      bht[commit_idx] <= rob_to_if_br_taken ? sat_inc(bht[commit_idx])
                                            : sat_dec(bht[commit_idx]);
    end
  end

  // ---- stage boundary: fetch FSM and registered decoder/memctrl outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= '0;
      state        <= S_IDLE;
      mc_en_p1     <= 1'b0;
      mc_pc_p1     <= '0;
      dc_vld_p1    <= 1'b0;
      dc_inst_p1   <= '0;
      dc_openum_p1 <= OPENUM_NOP;
      dc_pc_p1     <= '0;
      dc_pred_p1   <= 1'b0;
      dc_lsb_p1    <= 1'b0;
      dc_rs_p1     <= 1'b0;
    end else if (rdy) begin
      if (clr) begin
        pc        <= rob_to_if_set_pc;
        state     <= S_IDLE;
        dc_vld_p1 <= 1'b0;
        mc_en_p1  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!hit) begin
              dc_vld_p1 <= 1'b0;
              state     <= S_MEM_WAIT;
              mc_en_p1  <= 1'b1;
              mc_pc_p1  <= {pc[31:2], 2'b00};
            end else if (stall) begin
              dc_vld_p1 <= 1'b0;
            end else begin
              dc_vld_p1    <= 1'b1;
              dc_inst_p1   <= inst_p0;
              dc_openum_p1 <= openum_p0;
              dc_pc_p1     <= pc;
              dc_pred_p1   <= pred_p0;
              dc_lsb_p1    <= lsb_p0;
              dc_rs_p1     <= rs_p0;
              pc           <= next_pc;
            end
          end
          S_MEM_WAIT: begin
            if (bus.mc_to_if_done) begin
              mc_en_p1 <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.if_to_mc_enable     = mc_en_p1;
  assign bus.if_to_mc_pc         = mc_pc_p1;
  assign bus.if_to_dc_enable     = dc_vld_p1;
  assign bus.if_to_dc_inst_val   = dc_inst_p1;
  assign bus.if_to_dc_openum     = dc_openum_p1;
  assign bus.if_to_dc_pc         = dc_pc_p1;
  assign bus.if_to_dc_pred_jump  = dc_pred_p1;
  assign bus.if_to_dc_lsb_enable = dc_lsb_p1;
  assign bus.if_to_dc_rs_enable  = dc_rs_p1;

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed program with a fixed-latency memory
// model, a per-cycle vector table for the cached-loop stall/rdy behaviour and
// hand-written sequences for misses, redirects, BHT training and wrap.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam int  LAT = 2;
  localparam bit  O = 1'b0;
  localparam bit  I = 1'b1;

  logic  clk = 1'b0;
  logic  rst, rdy, clr, rob_full, rs_full, lsb_full;
  logic  br_commit, br_taken;
  addr_t set_pc, br_pc;

  always #5 clk = ~clk;

  ifetch_unit_if bus();

  ifetch_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .clr                 (clr),
    .rob_to_if_set_pc    (set_pc),
    .rob_full            (rob_full),
    .rs_full             (rs_full),
    .lsb_full            (lsb_full),
    .rob_to_if_br_commit (br_commit),
    .rob_to_if_br_pc     (br_pc),
    .rob_to_if_br_taken  (br_taken),
    .bus                 (bus)
  );

  // Memory controller model: done pulses LAT cycles after the request rises,
  // and the request is dropped whenever enable falls.
  inst_t mem [256];
  int    mcnt;
  logic  mdone;
  inst_t mdata;
  logic  inj_done;

  always @(posedge clk) begin
    if (rst || !bus.if_to_mc_enable || mdone) begin
      mcnt  <= 0;
      mdone <= 1'b0;
    end else if (mcnt == LAT - 1) begin
      mdone <= 1'b1;
      mdata <= mem[bus.if_to_mc_pc[9:2]];
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  assign bus.mc_to_if_done = mdone | inj_done;
  assign bus.mc_to_if_data = inj_done ? 32'hDEADBEEF : mdata;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next_inst(input addr_t epc, input inst_t einst, input openum_t eop,
                           input bit epred, input bit elsb);
    int n = 0;
    @(negedge clk);
    while (!bus.if_to_dc_enable && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("emit_timeout", 32'(bus.if_to_dc_enable), 32'd1);
    chk("dc_pc", bus.if_to_dc_pc, epc);
    chk("dc_inst", bus.if_to_dc_inst_val, einst);
    chk("dc_openum", 32'(bus.if_to_dc_openum), 32'(eop));
    chk("dc_pred", 32'(bus.if_to_dc_pred_jump), 32'(epred));
    chk("dc_lsb", 32'(bus.if_to_dc_lsb_enable), 32'(elsb));
    chk("dc_rs", 32'(bus.if_to_dc_rs_enable), 32'(!elsb));
  endtask

  task automatic redirect(input addr_t a);
    clr    = 1'b1;
    set_pc = a;
    @(negedge clk);
    chk("clr_dc_en", 32'(bus.if_to_dc_enable), 32'd0);
    chk("clr_mc_en", 32'(bus.if_to_mc_enable), 32'd0);
    clr = 1'b0;
  endtask

  task automatic commit(input addr_t a, input bit t);
    br_commit = 1'b1;
    br_pc     = a;
    br_taken  = t;
    @(negedge clk);
    br_commit = 1'b0;
  endtask

  task automatic wait_mc_en(input addr_t epc);
    int n = 0;
    while (!bus.if_to_mc_enable && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("mc_en_timeout", 32'(bus.if_to_mc_enable), 32'd1);
    chk("mc_pc", bus.if_to_mc_pc, epc);
  endtask

  typedef struct {
    bit    rob_full;
    bit    rs_full;
    bit    lsb_full;
    bit    rdy;
    bit    exp_en;
    addr_t exp_pc;
    bit    exp_pred;
  } vec_t;

  function automatic vec_t row(input bit a, input bit b, input bit c, input bit d,
                               input bit e, input addr_t p, input bit q);
    vec_t v;
    v.rob_full = a; v.rs_full = b; v.lsb_full = c; v.rdy = d;
    v.exp_en = e; v.exp_pc = p; v.exp_pred = q;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Checks apply to the outputs now; inputs are driven for the next edge.
    tbl[0]  = row(O, O, O, I, I, 32'h4, O);
    tbl[1]  = row(O, O, O, I, I, 32'h8, O);
    tbl[2]  = row(I, O, O, I, I, 32'hC, I);
    tbl[3]  = row(I, O, O, I, O, 32'hC, I);
    tbl[4]  = row(O, O, O, I, O, 32'hC, I);
    tbl[5]  = row(O, O, O, I, I, 32'h0, O);
    tbl[6]  = row(O, O, O, O, I, 32'h4, O);
    tbl[7]  = row(O, O, O, O, I, 32'h4, O);
    tbl[8]  = row(O, O, O, O, I, 32'h4, O);
    tbl[9]  = row(O, O, O, I, I, 32'h4, O);
    tbl[10] = row(O, O, O, I, I, 32'h8, O);
    tbl[11] = row(O, O, I, I, I, 32'hC, I);
    tbl[12] = row(O, O, O, I, O, 32'hC, I);
    tbl[13] = row(O, I, O, I, I, 32'h0, O);
    tbl[14] = row(O, O, O, I, O, 32'h0, O);
    tbl[15] = row(O, O, O, I, I, 32'h4, O);

    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[0]   = 32'h00500093;  // 0x000 addi x1,x0,5
    mem[1]   = 32'h00100113;  // 0x004 addi x2,x0,1
    mem[2]   = 32'h0000A183;  // 0x008 lw x3,0(x1)
    mem[3]   = 32'hFF5FF06F;  // 0x00C jal x0,-12
    mem[4]   = 32'h0100006F;  // 0x010 jal x0,+16
    mem[8]   = 32'h00102023;  // 0x020 sw x1,0(x0)
    mem[9]   = 32'h00C0006F;  // 0x024 jal x0,+12
    mem[12]  = 32'h02000063;  // 0x030 beq x0,x0,+32
    mem[13]  = 32'h00300213;  // 0x034 addi x4,x0,3
    mem[20]  = 32'h00700293;  // 0x050 addi x5,x0,7
    mem[192] = 32'h00600313;  // 0x300 addi x6,x0,6
    mem[208] = 32'h00900493;  // 0x340 addi x9,x0,9
    mem[255] = 32'h00800393;  // 0xFFFFFFFC addi x7,x0,8

    rst = 1'b1; rdy = 1'b1; clr = 1'b0; set_pc = '0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    br_commit = 1'b0; br_pc = '0; br_taken = 1'b0; inj_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dc_en", 32'(bus.if_to_dc_enable), 32'd0);
    chk("rst_mc_en", 32'(bus.if_to_mc_enable), 32'd0);
    chk("rst_dc_pc", bus.if_to_dc_pc, 32'h0);
    chk("rst_pred", 32'(bus.if_to_dc_pred_jump), 32'd0);
    rst = 1'b0;

    // First fetch: miss at 0, request, done, then emit two cycles after done.
    @(negedge clk);
    chk("t1_mc_en", 32'(bus.if_to_mc_enable), 32'd1);
    chk("t1_mc_pc", bus.if_to_mc_pc, 32'h0);
    chk("t1_dc_en_wait", 32'(bus.if_to_dc_enable), 32'd0);
    begin
      int n = 0;
      while (!bus.mc_to_if_done && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t1_done_seen", 32'(bus.mc_to_if_done), 32'd1);
    @(negedge clk);
    chk("t1_dc_en_fill", 32'(bus.if_to_dc_enable), 32'd0);
    chk("t1_mc_dropped", 32'(bus.if_to_mc_enable), 32'd0);
    @(negedge clk);
    chk("t1_dc_en", 32'(bus.if_to_dc_enable), 32'd1);
    chk("t1_dc_pc", bus.if_to_dc_pc, 32'h0);
    chk("t1_inst", bus.if_to_dc_inst_val, 32'h00500093);
    chk("t1_rs", 32'(bus.if_to_dc_rs_enable), 32'd1);
    chk("t1_lsb", 32'(bus.if_to_dc_lsb_enable), 32'd0);

    next_inst(32'h4, 32'h00100113, OPENUM_ALUI, O, O);
    next_inst(32'h8, 32'h0000A183, OPENUM_LD, O, I);
    next_inst(32'hC, 32'hFF5FF06F, OPENUM_JAL, I, O);
    next_inst(32'h0, 32'h00500093, OPENUM_ALUI, O, O);

    // Cached loop: back-to-back issue, stalls and rdy freeze.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_en", i), 32'(bus.if_to_dc_enable), 32'(tbl[i].exp_en));
      chk($sformatf("vec%0d_pc", i), bus.if_to_dc_pc, tbl[i].exp_pc);
      chk($sformatf("vec%0d_pred", i), 32'(bus.if_to_dc_pred_jump), 32'(tbl[i].exp_pred));
      chk($sformatf("vec%0d_mc", i), 32'(bus.if_to_mc_enable), 32'd0);
      rob_full = tbl[i].rob_full;
      rs_full  = tbl[i].rs_full;
      lsb_full = tbl[i].lsb_full;
      rdy      = tbl[i].rdy;
    end

    // JAL forward, store route, branch with fresh BHT.
    redirect(32'h10);
    next_inst(32'h10, 32'h0100006F, OPENUM_JAL, I, O);
    next_inst(32'h20, 32'h00102023, OPENUM_ST, O, I);
    next_inst(32'h24, 32'h00C0006F, OPENUM_JAL, I, O);
    next_inst(32'h30, 32'h02000063, OPENUM_BR, O, O);
    next_inst(32'h34, 32'h00300213, OPENUM_ALUI, O, O);

    // BHT 01 -> 10: predicted taken.
    commit(32'h30, I);
    redirect(32'h30);
    next_inst(32'h30, 32'h02000063, OPENUM_BR, I, O);
    next_inst(32'h50, 32'h00700293, OPENUM_ALUI, O, O);

    // 10 -> 01: not taken again.
    commit(32'h30, O);
    redirect(32'h30);
    next_inst(32'h30, 32'h02000063, OPENUM_BR, O, O);
    next_inst(32'h34, 32'h00300213, OPENUM_ALUI, O, O);

    // Low saturation: 01 -> 00 -> 00 -> 01.
    commit(32'h30, O);
    commit(32'h30, O);
    commit(32'h30, I);
    redirect(32'h30);
    next_inst(32'h30, 32'h02000063, OPENUM_BR, O, O);

    // High saturation: 01 -> 10 -> 11 -> 11 -> 10 -> 01.
    commit(32'h30, I);
    commit(32'h30, I);
    commit(32'h30, I);
    commit(32'h30, O);
    commit(32'h30, O);
    redirect(32'h30);
    next_inst(32'h30, 32'h02000063, OPENUM_BR, O, O);

    // Flush during MEM_WAIT; a stray done in IDLE must be ignored.
    redirect(32'h2C0);
    wait_mc_en(32'h2C0);
    clr    = 1'b1;
    set_pc = 32'h300;
    @(negedge clk);
    chk("t5_mc_drop", 32'(bus.if_to_mc_enable), 32'd0);
    clr      = 1'b0;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    chk("t5_new_req", 32'(bus.if_to_mc_enable), 32'd1);
    chk("t5_new_pc", bus.if_to_mc_pc, 32'h300);
    next_inst(32'h300, 32'h00600313, OPENUM_ALUI, O, O);

    // done and clr on the same edge: word still cached, next fetch hits.
    redirect(32'h340);
    wait_mc_en(32'h340);
    begin
      int n = 0;
      while (!bus.mc_to_if_done && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t7_done_seen", 32'(bus.mc_to_if_done), 32'd1);
    clr    = 1'b1;
    set_pc = 32'h340;
    @(negedge clk);
    chk("t7_clr_en", 32'(bus.if_to_dc_enable), 32'd0);
    chk("t7_clr_mc", 32'(bus.if_to_mc_enable), 32'd0);
    clr = 1'b0;
    @(negedge clk);
    chk("t7_hit_en", 32'(bus.if_to_dc_enable), 32'd1);
    chk("t7_hit_pc", bus.if_to_dc_pc, 32'h340);
    chk("t7_hit_inst", bus.if_to_dc_inst_val, 32'h00900493);
    chk("t7_no_req", 32'(bus.if_to_mc_enable), 32'd0);

    // PC wraps from the last word to 0.
    redirect(32'hFFFFFFFC);
    next_inst(32'hFFFFFFFC, 32'h00800393, OPENUM_ALUI, O, O);
    next_inst(32'h0, 32'h00500093, OPENUM_ALUI, O, O);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
